clause_operand_builder: RTL and testbench
=========================================

Name: clause_operand_builder

Overview:
- Producer side of the unit-clause evaluator interface in the SAT solver.
- Walks a contiguous range of clause indices and reads each clause from clause memory (1-cycle read latency).
- Merges each clause with the internal variable-assignment table to build the evaluator operands (unassign, clause_mask, clause_pole, variable) and presents them over a valid/ready handshake.
- Optionally drops clauses already satisfied so the evaluator only sees live clauses.

Parameters:
- VAR_PER_CLAUSE, 5, literal slots per clause
- NUM_VARIABLE, 128, variable count; VARIABLE_INDEX = $clog2(NUM_VARIABLE)-1
- NUM_CLAUSE, 256, clause memory depth; CLAUSE_INDEX = $clog2(NUM_CLAUSE)-1
- SKIP_SAT, 1, 1 = satisfied clauses are never presented

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a walk; ignored while busy
- clause_base  in  CLAUSE_INDEX+1  first clause index
- clause_count  in  CLAUSE_INDEX+2  number of clauses, 0..NUM_CLAUSE
- busy  out  1  walk in progress
- done  out  1  one-cycle pulse at end of walk
- cmem_rd_en  out  1  clause memory read strobe
- cmem_rd_addr  out  CLAUSE_INDEX+1  clause memory address
- cmem_rd_var  in  [VAR_PER_CLAUSE-1:0][VARIABLE_INDEX:0]  slot variable ids, valid the cycle after cmem_rd_en
- cmem_rd_mask  in  VAR_PER_CLAUSE  slot-used bits
- cmem_rd_pole  in  VAR_PER_CLAUSE  1 = positive literal
- asgn_wr_en  in  1  assignment-table write
- asgn_wr_var  in  VARIABLE_INDEX+1  variable written
- asgn_wr_assigned  in  1  1 = assign, 0 = unassign (backtrack)
- asgn_wr_value  in  1  assigned truth value
- out_valid  out  1  operands valid
- out_ready  in  1  evaluator accepts
- unassign  out  VAR_PER_CLAUSE  1 = slot used and variable unassigned
- clause_mask  out  VAR_PER_CLAUSE  registered cmem_rd_mask
- clause_pole  out  VAR_PER_CLAUSE  registered cmem_rd_pole
- variable  out  [VAR_PER_CLAUSE-1:0][VARIABLE_INDEX:0]  registered cmem_rd_var
- out_clause_id  out  CLAUSE_INDEX+1  clause index of presented operands
- out_last  out  1  presented clause is last in range

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All assignment-table entries become unassigned, value 0.
  - All outputs are 0.
  - Reset mid-walk aborts the walk with no done pulse.
- FSM states: IDLE, FETCH, WAIT, BUILD, PRESENT.
- IDLE:
  - start with clause_count != 0 → FETCH; latch base and count; k = 0; busy = 1.
  - start with clause_count == 0 → done pulses the next cycle; busy stays 0.
- FETCH: cmem_rd_en = 1; cmem_rd_addr = (base+k) mod NUM_CLAUSE (wraps); → WAIT.
- WAIT: memory data valid; → BUILD.
- BUILD: register the operands.
  - unassign[i] = mask[i] & ~assigned[var[i]]
  - sat = OR over i of mask[i] & assigned[var[i]] & (value[var[i]] == pole[i])
  - If SKIP_SAT and sat: go to next clause without presenting it.
  - Otherwise → PRESENT with out_valid = 1.
- PRESENT:
  - All operand outputs are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: k++. If k was count-1 → IDLE and pulse done in the same cycle as the final transfer; else → FETCH.
- Skipping the last clause: → IDLE, done pulses that cycle, out_last is never seen.
- out_last = (k == count-1) while presented.
- Latency: start to first out_valid = 3 cycles (FETCH, WAIT, BUILD). Minimum 4 cycles per presented clause with ready held high.
- Assignment table:
  - Write takes effect at the clock edge.
  - BUILD reads pre-write state when a write lands in the same cycle.
  - Writes never alter operands already in PRESENT.
- Writes are accepted in every state.
- start during busy is ignored.

Decomposition:
- sat_pkg holds VAR_PER_CLAUSE, NUM_VARIABLE, NUM_CLAUSE defaults and derived index widths.
- sat_pkg holds typedefs var_id_t, clause_id_t, lit_slots_t, and the FSM state enum.
- Sub-module assignment_table: register array with one write port and VAR_PER_CLAUSE combinational read ports returning assigned/value; reset clears it.

Test Plan:
- Reset, then start base=0, count=1; mem[0]: var={1,2,3,4,5}, mask=11111, pole=00000; var 2..5 assigned 1 → out_valid on cycle 3; unassign=00001 (slot 0, var 1); out_last=1; done on handshake.
- Same clause, var 2 assigned 0, SKIP_SAT=1 → no out_valid; done pulses; busy drops.
- base=254, count=4, NUM_CLAUSE=256 → addresses 254,255,0,1 in order; out_clause_id matches; out_last only on id 1.
- out_ready held 0 for 5 cycles with asgn_wr on a presented variable → outputs unchanged; transfer when ready rises.
- count=0 → done next cycle, no cmem_rd_en. start while busy → ignored.
- reset asserted during WAIT → all outputs 0 next cycle; table cleared; no done.

Source files
------------

// File: rtl/clause_operand_builder_pkg.sv
// Shared sizing defaults, index types and FSM states for the clause operand builder.
package clause_operand_builder_pkg;

    localparam int DEF_VAR_PER_CLAUSE = 5;
    localparam int DEF_NUM_VARIABLE   = 128;
    localparam int DEF_NUM_CLAUSE     = 256;
    localparam int DEF_VARIABLE_INDEX = $clog2(DEF_NUM_VARIABLE) - 1;
    localparam int DEF_CLAUSE_INDEX   = $clog2(DEF_NUM_CLAUSE) - 1;

    typedef logic [DEF_VARIABLE_INDEX:0] var_id_t;
    typedef logic [DEF_CLAUSE_INDEX:0]   clause_id_t;
    typedef logic [DEF_VAR_PER_CLAUSE-1:0] lit_slots_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_BUILD,
        ST_PRESENT
    } state_t;

endpackage

// File: rtl/clause_operand_builder_if.sv
// Operand channel from the clause operand builder to the unit-clause evaluator.
interface clause_operand_builder_if
    import clause_operand_builder_pkg::*;
#(
    parameter int VAR_PER_CLAUSE = DEF_VAR_PER_CLAUSE,
    parameter int NUM_VARIABLE   = DEF_NUM_VARIABLE,
    parameter int NUM_CLAUSE     = DEF_NUM_CLAUSE
);
    localparam int VI = $clog2(NUM_VARIABLE);
    localparam int CI = $clog2(NUM_CLAUSE);

    logic                                out_valid;
    logic                                out_ready;
    logic [VAR_PER_CLAUSE-1:0]           unassign;
    logic [VAR_PER_CLAUSE-1:0]           clause_mask;
    logic [VAR_PER_CLAUSE-1:0]           clause_pole;
    logic [VAR_PER_CLAUSE-1:0][VI-1:0]   variable;
    logic [CI-1:0]                       out_clause_id;
    logic                                out_last;

    modport master (
        output out_valid, unassign, clause_mask, clause_pole, variable, out_clause_id, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, unassign, clause_mask, clause_pole, variable, out_clause_id, out_last,
        output out_ready
    );

endinterface

// File: rtl/clause_operand_builder_assignment_table.sv
// Variable assignment table: one write port, one combinational read port per literal slot.
module assignment_table
    import clause_operand_builder_pkg::*;
#(
    parameter int VAR_PER_CLAUSE = DEF_VAR_PER_CLAUSE,
    parameter int NUM_VARIABLE   = DEF_NUM_VARIABLE,
    localparam int VI            = $clog2(NUM_VARIABLE)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [VI-1:0]                     wr_var,
    input  logic                              wr_assigned,
    input  logic                              wr_value,
    input  logic [VAR_PER_CLAUSE-1:0][VI-1:0] rd_var,
    output logic [VAR_PER_CLAUSE-1:0]         rd_assigned,
    output logic [VAR_PER_CLAUSE-1:0]         rd_value
);

    logic [NUM_VARIABLE-1:0] assigned_reg;
    logic [NUM_VARIABLE-1:0] value_reg;

    // Unassigning a variable also zeroes its value so a backtracked entry matches reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            assigned_reg <= '0;
            value_reg    <= '0;
        end else if (wr_en) begin
            assigned_reg[wr_var] <= wr_assigned;
            value_reg[wr_var]    <= wr_assigned & wr_value;
        end
    end

    generate
        for (genvar gi = 0; gi < VAR_PER_CLAUSE; gi++) begin : g_rd
            assign rd_assigned[gi] = assigned_reg[rd_var[gi]];
            assign rd_value[gi]    = value_reg[rd_var[gi]];
        end
    endgenerate

endmodule

// File: rtl/clause_operand_builder.sv
// Walks a clause range, merges each clause with the assignment table and presents
// evaluator operands over valid/ready, optionally dropping satisfied clauses.
module clause_operand_builder
    import clause_operand_builder_pkg::*;
#(
    parameter int VAR_PER_CLAUSE  = DEF_VAR_PER_CLAUSE,
    parameter int NUM_VARIABLE    = DEF_NUM_VARIABLE,
    parameter int NUM_CLAUSE      = DEF_NUM_CLAUSE,
    parameter bit SKIP_SAT        = 1'b1,
    localparam int VARIABLE_INDEX = $clog2(NUM_VARIABLE) - 1,
    localparam int CLAUSE_INDEX   = $clog2(NUM_CLAUSE) - 1
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [CLAUSE_INDEX:0]                         clause_base,
    input  logic [CLAUSE_INDEX+1:0]                       clause_count,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          cmem_rd_en,
    output logic [CLAUSE_INDEX:0]                         cmem_rd_addr,
    input  logic [VAR_PER_CLAUSE-1:0][VARIABLE_INDEX:0]   cmem_rd_var,
    input  logic [VAR_PER_CLAUSE-1:0]                     cmem_rd_mask,
    input  logic [VAR_PER_CLAUSE-1:0]                     cmem_rd_pole,
    input  logic                                          asgn_wr_en,
    input  logic [VARIABLE_INDEX:0]                       asgn_wr_var,
    input  logic                                          asgn_wr_assigned,
    input  logic                                          asgn_wr_value,
    clause_operand_builder_if.master                      ev
);

    localparam logic [CLAUSE_INDEX:0] LAST_ADDR = (CLAUSE_INDEX+1)'(NUM_CLAUSE - 1);

    state_t                                       state_reg;
    logic [CLAUSE_INDEX+1:0]                      count_reg;
    logic [CLAUSE_INDEX+1:0]                      k_reg;
    logic [VAR_PER_CLAUSE-1:0][VARIABLE_INDEX:0]  var_reg;
    logic [VAR_PER_CLAUSE-1:0]                    mask_reg;
    logic [VAR_PER_CLAUSE-1:0]                    pole_reg;
    logic                                         done_reg;

    logic [VAR_PER_CLAUSE-1:0] slot_assigned;
    logic [VAR_PER_CLAUSE-1:0] slot_value;
    logic [VAR_PER_CLAUSE-1:0] unassign_next;
    logic [VAR_PER_CLAUSE-1:0] slot_sat;
    logic                      sat;
    logic                      skip;
    logic                      is_last;
    logic [CLAUSE_INDEX:0]     next_addr;

    assignment_table #(
        .VAR_PER_CLAUSE (VAR_PER_CLAUSE),
        .NUM_VARIABLE   (NUM_VARIABLE)
    ) u_table (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (asgn_wr_en),
        .wr_var      (asgn_wr_var),
        .wr_assigned (asgn_wr_assigned),
        .wr_value    (asgn_wr_value),
        .rd_var      (var_reg),
        .rd_assigned (slot_assigned),
        .rd_value    (slot_value)
    );

    generate
        for (genvar gi = 0; gi < VAR_PER_CLAUSE; gi++) begin : g_slot
            assign unassign_next[gi] = mask_reg[gi] & ~slot_assigned[gi];
            assign slot_sat[gi]      = mask_reg[gi] & slot_assigned[gi] & (slot_value[gi] == pole_reg[gi]);
        end
    endgenerate

    assign sat       = |slot_sat;
    assign skip      = SKIP_SAT && sat;
    assign is_last   = (k_reg == count_reg - 1'b1);
    assign next_addr = (cmem_rd_addr == LAST_ADDR) ? '0 : cmem_rd_addr + 1'b1;

    // done must coincide with the final transfer (or final skip), so those terms
    // are decoded from the current cycle; an empty walk uses the registered pulse.
    assign done = done_reg
                | ((state_reg == ST_PRESENT) && ev.out_ready && ev.out_last)
                | ((state_reg == ST_BUILD) && skip && is_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            count_reg        <= '0;
            k_reg            <= '0;
            var_reg          <= '0;
            mask_reg         <= '0;
            pole_reg         <= '0;
            done_reg         <= 1'b0;
            busy             <= 1'b0;
            cmem_rd_en       <= 1'b0;
            cmem_rd_addr     <= '0;
            ev.out_valid     <= 1'b0;
            ev.unassign      <= '0;
            ev.clause_mask   <= '0;
            ev.clause_pole   <= '0;
            ev.variable      <= '0;
            ev.out_clause_id <= '0;
            ev.out_last      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (clause_count != '0) begin
                            state_reg    <= ST_FETCH;
                            busy         <= 1'b1;
                            count_reg    <= clause_count;
                            k_reg        <= '0;
                            cmem_rd_en   <= 1'b1;
                            cmem_rd_addr <= clause_base;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    cmem_rd_en <= 1'b0;
                    state_reg  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Capture the memory word so BUILD does not depend on read-data hold time.
                    var_reg   <= cmem_rd_var;
                    mask_reg  <= cmem_rd_mask;
                    pole_reg  <= cmem_rd_pole;
                    state_reg <= ST_BUILD;
                end
                ST_BUILD: begin
                    if (skip) begin
                        if (is_last) begin
                            state_reg <= ST_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            k_reg        <= k_reg + 1'b1;
                            cmem_rd_addr <= next_addr;
                            cmem_rd_en   <= 1'b1;
                            state_reg    <= ST_FETCH;
                        end
                    end else begin
                        ev.unassign      <= unassign_next;
                        ev.clause_mask   <= mask_reg;
                        ev.clause_pole   <= pole_reg;
                        ev.variable      <= var_reg;
                        ev.out_clause_id <= cmem_rd_addr;
                        ev.out_last      <= is_last;
                        ev.out_valid     <= 1'b1;
                        state_reg        <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ev.out_ready) begin
                        ev.out_valid <= 1'b0;
                        ev.out_last  <= 1'b0;
                        if (is_last) begin
                            state_reg <= ST_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            k_reg        <= k_reg + 1'b1;
                            cmem_rd_addr <= next_addr;
                            cmem_rd_en   <= 1'b1;
                            state_reg    <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clause_operand_builder.sv
// Self-checking bench for clause_operand_builder: directed vector table, corner-case
// sequences and randomized walks against a clause-level reference model.
module tb_clause_operand_builder;
    import clause_operand_builder_pkg::*;

    localparam int VPC = DEF_VAR_PER_CLAUSE;
    localparam int NV  = DEF_NUM_VARIABLE;
    localparam int NC  = DEF_NUM_CLAUSE;

    logic                                   clock = 1'b0;
    logic                                   reset;
    logic                                   start;
    clause_id_t                             clause_base;
    logic [DEF_CLAUSE_INDEX+1:0]            clause_count;
    logic                                   busy;
    logic                                   done;
    logic                                   cmem_rd_en;
    clause_id_t                             cmem_rd_addr;
    logic [VPC-1:0][DEF_VARIABLE_INDEX:0]   cmem_rd_var;
    lit_slots_t                             cmem_rd_mask;
    lit_slots_t                             cmem_rd_pole;
    logic                                   asgn_wr_en;
    var_id_t                                asgn_wr_var;
    logic                                   asgn_wr_assigned;
    logic                                   asgn_wr_value;

    clause_operand_builder_if #(.VAR_PER_CLAUSE(VPC), .NUM_VARIABLE(NV), .NUM_CLAUSE(NC)) ev ();

    clause_operand_builder #(
        .VAR_PER_CLAUSE (VPC),
        .NUM_VARIABLE   (NV),
        .NUM_CLAUSE     (NC),
        .SKIP_SAT       (1'b1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .clause_base      (clause_base),
        .clause_count     (clause_count),
        .busy             (busy),
        .done             (done),
        .cmem_rd_en       (cmem_rd_en),
        .cmem_rd_addr     (cmem_rd_addr),
        .cmem_rd_var      (cmem_rd_var),
        .cmem_rd_mask     (cmem_rd_mask),
        .cmem_rd_pole     (cmem_rd_pole),
        .asgn_wr_en       (asgn_wr_en),
        .asgn_wr_var      (asgn_wr_var),
        .asgn_wr_assigned (asgn_wr_assigned),
        .asgn_wr_value    (asgn_wr_value),
        .ev               (ev)
    );

    always #5 clock = ~clock;

    // Clause memory with one-cycle registered read.
    logic [VPC-1:0][DEF_VARIABLE_INDEX:0] mem_var  [NC];
    lit_slots_t                           mem_mask [NC];
    lit_slots_t                           mem_pole [NC];

    always @(posedge clock) begin
        if (cmem_rd_en) begin
            cmem_rd_var  <= mem_var[cmem_rd_addr];
            cmem_rd_mask <= mem_mask[cmem_rd_addr];
            cmem_rd_pole <= mem_pole[cmem_rd_addr];
        end
    end

    // Reference assignment table.
    bit ref_assigned [NV];
    bit ref_value    [NV];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] xfer_q[$];
    logic [63:0] exp_xfer[$];
    int          addr_q[$];
    int          exp_addr[$];
    int          done_cnt;
    int          done_xfer;
    int          exp_done_xfer;
    int          first_lat;
    bit          busy_seen;
    bit          finished;

    typedef struct {
        int         base;
        lit_slots_t mask;
        lit_slots_t pole;
        lit_slots_t asg;
        lit_slots_t val;
        bit         present;
        lit_slots_t unassign;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [63:0] pack(input logic [7:0] id, input lit_slots_t un,
                                         input lit_slots_t mask, input lit_slots_t pole,
                                         input logic [VPC-1:0][DEF_VARIABLE_INDEX:0] vars,
                                         input logic last);
        return {5'd0, id, un, mask, pole, vars, last};
    endfunction

    function automatic logic [63:0] dut_pack();
        return pack(ev.out_clause_id, ev.unassign, ev.clause_mask, ev.clause_pole, ev.variable, ev.out_last);
    endfunction

    task automatic write_asgn(input int v, input bit a, input bit val);
        asgn_wr_en       = 1'b1;
        asgn_wr_var      = var_id_t'(v);
        asgn_wr_assigned = a;
        asgn_wr_value    = val;
        tick();
        asgn_wr_en       = 1'b0;
        ref_assigned[v]  = a;
        ref_value[v]     = a & val;
    endtask

    // Clause-level model: which clauses are read, which are presented, and what they carry.
    function automatic void build_expect(input int base, input int count);
        exp_addr.delete();
        exp_xfer.delete();
        exp_done_xfer = 0;
        for (int k = 0; k < count; k++) begin
            int         a;
            lit_slots_t un;
            bit         sat;
            a   = (base + k) % NC;
            un  = '0;
            sat = 1'b0;
            for (int i = 0; i < VPC; i++) begin
                int vid;
                vid = int'(mem_var[a][i]);
                if (mem_mask[a][i] && !ref_assigned[vid]) un[i] = 1'b1;
                if (mem_mask[a][i] && ref_assigned[vid] && (ref_value[vid] == mem_pole[a][i])) sat = 1'b1;
            end
            exp_addr.push_back(a);
            if (!sat) begin
                exp_xfer.push_back(pack(8'(a), un, mem_mask[a], mem_pole[a], mem_var[a], k == count - 1));
                if (k == count - 1) exp_done_xfer = 1;
            end
        end
    endfunction

    // ready_mode 0: out_ready always high; 1: random. poke re-asserts start mid-walk.
    task automatic walk(input int base, input int count, input int ready_mode, input bit poke);
        build_expect(base, count);
        xfer_q.delete();
        addr_q.delete();
        done_cnt     = 0;
        done_xfer    = 0;
        first_lat    = -1;
        busy_seen    = 1'b0;
        finished     = 1'b0;
        clause_base  = clause_id_t'(base);
        clause_count = (DEF_CLAUSE_INDEX+2)'(count);
        start        = 1'b1;
        ev.out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ev.out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (poke && i == 4) begin
                start       = 1'b1;
                clause_base = clause_id_t'(base + 100);
            end else begin
                start       = 1'b0;
                clause_base = clause_id_t'(base);
            end
            #1;
            if (ev.out_valid && first_lat < 0) first_lat = i;
            if (busy) busy_seen = 1'b1;
            if (cmem_rd_en) addr_q.push_back(int'(cmem_rd_addr));
            if (ev.out_valid && ev.out_ready) xfer_q.push_back(dut_pack());
            if (done) begin
                done_cnt++;
                if (ev.out_valid && ev.out_ready) done_xfer++;
            end
            tick();
            if (!busy && done_cnt > 0) begin
                finished = 1'b1;
                break;
            end
        end
        start        = 1'b0;
        ev.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (done) done_cnt++;
            if (cmem_rd_en) addr_q.push_back(int'(cmem_rd_addr));
            tick();
        end
        $display("walk base=%0d count=%0d read=%0d presented=%0d done=%0d", base, count,
                 addr_q.size(), xfer_q.size(), done_cnt);
    endtask

    task automatic compare_walk(input string tag, input int count);
        check({tag, "_finished"}, finished, 1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_seen"}, busy_seen, count != 0);
        check({tag, "_done_on_xfer"}, done_xfer, exp_done_xfer);
        check({tag, "_n_addr"}, addr_q.size(), exp_addr.size());
        for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), addr_q[i], exp_addr[i]);
        check({tag, "_n_xfer"}, xfer_q.size(), exp_xfer.size());
        for (int i = 0; i < xfer_q.size() && i < exp_xfer.size(); i++)
            check($sformatf("%s_xfer%0d", tag, i), xfer_q[i], exp_xfer[i]);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         stray;
        logic [63:0] exp_rec;
        bit          seen;

        vecs[0] = '{0,   5'b11111, 5'b00000, 5'b11110, 5'b11110, 1'b1, 5'b00001};
        vecs[1] = '{0,   5'b11111, 5'b00000, 5'b11110, 5'b11100, 1'b0, 5'b00000};
        vecs[2] = '{3,   5'b00000, 5'b10101, 5'b11111, 5'b00000, 1'b1, 5'b00000};
        vecs[3] = '{17,  5'b10101, 5'b10101, 5'b00000, 5'b00000, 1'b1, 5'b10101};
        vecs[4] = '{40,  5'b10101, 5'b11111, 5'b11111, 5'b01010, 1'b1, 5'b00000};
        vecs[5] = '{99,  5'b01010, 5'b00000, 5'b01000, 5'b00000, 1'b0, 5'b00000};
        vecs[6] = '{128, 5'b11111, 5'b01010, 5'b10001, 5'b10001, 1'b1, 5'b01110};
        vecs[7] = '{200, 5'b00001, 5'b00001, 5'b11110, 5'b11110, 1'b1, 5'b00001};
        vecs[8] = '{255, 5'b00110, 5'b00100, 5'b00110, 5'b00100, 1'b0, 5'b00000};
        vecs[9] = '{77,  5'b11000, 5'b10000, 5'b11000, 5'b01000, 1'b1, 5'b00000};

        for (int a = 0; a < NC; a++) begin
            for (int i = 0; i < VPC; i++) mem_var[a][i] = 7'($urandom_range(0, 15));
            mem_mask[a] = 5'($urandom);
            mem_pole[a] = 5'($urandom);
        end
        for (int v = 0; v < NV; v++) begin
            ref_assigned[v] = 1'b0;
            ref_value[v]    = 1'b0;
        end

        reset            = 1'b1;
        start            = 1'b0;
        clause_base      = '0;
        clause_count     = '0;
        asgn_wr_en       = 1'b0;
        asgn_wr_var      = '0;
        asgn_wr_assigned = 1'b0;
        asgn_wr_value    = 1'b0;
        ev.out_ready     = 1'b0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", cmem_rd_en, 0);
        check("reset_rd_addr", cmem_rd_addr, 0);
        check("reset_valid", ev.out_valid, 0);
        check("reset_operands", dut_pack(), 0);
        reset = 1'b0;
        tick();

        // Directed single-clause vectors over variables 1..5.
        foreach (vecs[n]) begin
            for (int i = 0; i < VPC; i++) begin
                mem_var[vecs[n].base][i] = 7'(i + 1);
                write_asgn(i + 1, vecs[n].asg[i], vecs[n].val[i]);
            end
            mem_mask[vecs[n].base] = vecs[n].mask;
            mem_pole[vecs[n].base] = vecs[n].pole;
            walk(vecs[n].base, 1, 0, 1'b0);
            check($sformatf("vec%0d_presented", n), xfer_q.size(), vecs[n].present);
            check($sformatf("vec%0d_done_cnt", n), done_cnt, 1);
            if (vecs[n].present && xfer_q.size() == 1) begin
                exp_rec = pack(8'(vecs[n].base), vecs[n].unassign, vecs[n].mask, vecs[n].pole,
                               mem_var[vecs[n].base], 1'b1);
                check($sformatf("vec%0d_operands", n), xfer_q[0], exp_rec);
                check($sformatf("vec%0d_latency", n), first_lat, 3);
                check($sformatf("vec%0d_done_on_xfer", n), done_xfer, 1);
            end
        end

        // Empty range: done next cycle, no reads, never busy.
        walk(5, 0, 0, 1'b0);
        compare_walk("count0", 0);

        // Address wrap across the top of clause memory.
        walk(254, 4, 0, 1'b0);
        compare_walk("wrap", 4);

        // Randomized walks with random back-pressure and occasional start while busy.
        for (int r = 0; r < 16; r++) begin
            int base;
            int count;
            for (int v = 0; v < 16; v++) write_asgn(v, $urandom_range(0, 1), $urandom_range(0, 1));
            base  = $urandom_range(0, NC - 1);
            count = (r % 5 == 4) ? $urandom_range(20, 40) : $urandom_range(0, 10);
            walk(base, count, 1, count >= 3 && (r % 2 == 0));
            compare_walk($sformatf("rand%0d", r), count);
        end

        // Reset while the first clause read is in WAIT.
        for (int i = 0; i < VPC; i++) begin
            mem_var[50][i] = 7'(i + 1);
            write_asgn(i + 1, 1'b1, 1'b1);
        end
        mem_mask[50] = 5'b11111;
        mem_pole[50] = 5'b00000;
        clause_base  = 8'd50;
        clause_count = 9'd3;
        start        = 1'b1;
        ev.out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stray = 0;
        if (done) stray++;
        reset = 1'b1;
        tick();
        check("rstwait_busy", busy, 0);
        check("rstwait_done", done, 0);
        check("rstwait_rd_en", cmem_rd_en, 0);
        check("rstwait_rd_addr", cmem_rd_addr, 0);
        check("rstwait_valid", ev.out_valid, 0);
        check("rstwait_operands", dut_pack(), 0);
        reset = 1'b0;
        for (int v = 0; v < NV; v++) begin
            ref_assigned[v] = 1'b0;
            ref_value[v]    = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            #1;
            if (done || ev.out_valid || cmem_rd_en) stray++;
            tick();
        end
        check("rstwait_no_activity", stray, 0);
        walk(50, 1, 0, 1'b0);
        compare_walk("after_reset", 1);

        // Back-pressure with table writes on the presented variables.
        for (int i = 0; i < VPC; i++) mem_var[10][i] = 7'(i + 1);
        mem_mask[10] = 5'b11111;
        mem_pole[10] = 5'b00000;
        build_expect(10, 1);
        exp_rec      = exp_xfer[0];
        clause_base  = 8'd10;
        clause_count = 9'd1;
        ev.out_ready = 1'b0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ev.out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("hold_valid_seen", seen, 1);
        for (int j = 0; j < 5; j++) begin
            asgn_wr_en       = 1'b1;
            asgn_wr_var      = var_id_t'(j + 1);
            asgn_wr_assigned = 1'b1;
            asgn_wr_value    = j[0];
            ref_assigned[j + 1] = 1'b1;
            ref_value[j + 1]    = j[0];
            tick();
            check($sformatf("hold_valid%0d", j), ev.out_valid, 1);
            check($sformatf("hold_operands%0d", j), dut_pack(), exp_rec);
        end
        asgn_wr_en   = 1'b0;
        ev.out_ready = 1'b1;
        #1;
        check("hold_done_on_xfer", done, 1);
        tick();
        ev.out_ready = 1'b0;
        check("hold_valid_after", ev.out_valid, 0);
        check("hold_busy_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
